// File: rtl/maze_pkg.sv
// Shared maze definitions: screen state codes, play sub-states, move directions.
// Imported by the game controller and the pixel renderer.
package maze_pkg;

  localparam int MAX_NUM    = 19;
  localparam int MIN_NUM    = 5;
  localparam int MAP_BITS   = MAX_NUM * MAX_NUM;
  localparam int MOVE_CNT_W = 10;

  typedef enum logic [1:0] {
    ST_WELCOME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_WIN     = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SUB_IDLE   = 2'b00,
    SUB_CHECK  = 2'b01,
    SUB_COMMIT = 2'b10
  } play_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  // Target cell one step away; 6 bits so a step left/up from 0 shows as negative.
  function automatic logic [11:0] step_target(dir_e d, logic [4:0] x, logic [4:0] y);
    logic [5:0] tx;
    logic [5:0] ty;
    tx = {1'b0, x};
    ty = {1'b0, y};
    case (d)
      DIR_UP:   ty = ty - 6'd1;
      DIR_DOWN: ty = ty + 6'd1;
      DIR_LEFT: tx = tx - 6'd1;
      default:  tx = tx + 6'd1;
    endcase
    return {tx, ty};
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous debounced button, followed by a
// rising-edge detector giving a single-cycle pulse.
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign pulse_o = s2_q & ~prev_q;

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game sequencer: screen state, player cell and move counter; each legal
// move is range-checked, indexed and wall-checked over three cycles.
module maze_game_ctrl #(
  parameter int MAX_NUM    = 19,
  parameter int MAP_BITS   = 361,
  parameter int MOVE_CNT_W = 10
) (
  input  logic                  vga_clk,
  input  logic                  rst_sys,
  input  logic                  btn_start,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic [4:0]            num,
  input  logic [MAP_BITS-1:0]   map,
  output logic [1:0]            state,
  output logic [4:0]            x_index,
  output logic [4:0]            y_index,
  output logic [MOVE_CNT_W-1:0] move_count,
  output logic                  busy
);

  import maze_pkg::*;

  logic                  start_p, up_p, down_p, left_p, right_p;
  logic                  dir_one;
  dir_e                  dir;
  logic [4:0]            num_clamped;

  state_e                state_q;
  play_e                 sub_q;
  logic [4:0]            x_q, y_q, num_q;
  logic [5:0]            tx_q, ty_q;
  logic [8:0]            idx_q;
  logic                  inrng_q;
  logic                  busy_q;
  logic [MOVE_CNT_W-1:0] cnt_q;

  btn_sync_edge u_sync_start (.clk_i(vga_clk), .rst_ni(rst_sys), .btn_i(btn_start), .pulse_o(start_p));
  btn_sync_edge u_sync_up    (.clk_i(vga_clk), .rst_ni(rst_sys), .btn_i(btn_up),    .pulse_o(up_p));
  btn_sync_edge u_sync_down  (.clk_i(vga_clk), .rst_ni(rst_sys), .btn_i(btn_down),  .pulse_o(down_p));
  btn_sync_edge u_sync_left  (.clk_i(vga_clk), .rst_ni(rst_sys), .btn_i(btn_left),  .pulse_o(left_p));
  btn_sync_edge u_sync_right (.clk_i(vga_clk), .rst_ni(rst_sys), .btn_i(btn_right), .pulse_o(right_p));

  always_comb begin
    dir_one = $onehot({up_p, down_p, left_p, right_p});
    dir     = DIR_RIGHT;
    if (up_p)        dir = DIR_UP;
    else if (down_p) dir = DIR_DOWN;
    else if (left_p) dir = DIR_LEFT;
    num_clamped = num;
    if (num < 5'd5)                num_clamped = 5'd5;
    else if (num > 5'(MAX_NUM))    num_clamped = 5'(MAX_NUM);
  end

  always_ff @(posedge vga_clk or negedge rst_sys) begin
    if (!rst_sys) begin
      state_q <= ST_WELCOME;
      sub_q   <= SUB_IDLE;
      x_q     <= 5'd1;
      y_q     <= 5'd1;
      num_q   <= 5'd5;
      tx_q    <= 6'd0;
      ty_q    <= 6'd0;
      idx_q   <= 9'd0;
      inrng_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_WELCOME: begin
          x_q    <= 5'd1;
          y_q    <= 5'd1;
          cnt_q  <= '0;
          busy_q <= 1'b0;
          sub_q  <= SUB_IDLE;
          if (start_p) begin
            num_q   <= num_clamped;
            state_q <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          case (sub_q)
            SUB_IDLE: begin
              if (x_q == num_q - 5'd2 && y_q == num_q - 5'd2) begin
                state_q <= ST_WIN;
              end else if (dir_one) begin
                {tx_q, ty_q} <= step_target(dir, x_q, y_q);
                busy_q       <= 1'b1;
                sub_q        <= SUB_CHECK;
              end
            end
            SUB_CHECK: begin
              // Bit 5 set means the step went below zero.
              inrng_q <= !tx_q[5] && !ty_q[5] && (tx_q[4:0] < num_q) && (ty_q[4:0] < num_q);
              idx_q   <= 9'(ty_q[4:0]) * 9'(num_q) + 9'(tx_q[4:0]);
              sub_q   <= SUB_COMMIT;
            end
            SUB_COMMIT: begin
              if (inrng_q && !map[idx_q]) begin
                x_q <= tx_q[4:0];
                y_q <= ty_q[4:0];
                if (cnt_q != {MOVE_CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
              end
              busy_q <= 1'b0;
              sub_q  <= SUB_IDLE;
            end
            default: sub_q <= SUB_IDLE;
          endcase
        end
        ST_WIN: begin
          if (start_p) begin
            state_q <= ST_WELCOME;
            x_q     <= 5'd1;
            y_q     <= 5'd1;
            cnt_q   <= '0;
          end
        end
        default: state_q <= ST_WELCOME;
      endcase
    end
  end

  assign state      = state_q;
  assign x_index    = x_q;
  assign y_index    = y_q;
  assign move_count = cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Directed bench for maze_game_ctrl: stimulus pushes expected move and screen
// results into queues, a negedge monitor pops them as the DUT reports them.
module tb_maze_game_ctrl;

  localparam int MAP_BITS = 361;

  logic                vga_clk;
  logic                rst_sys;
  logic                btn_start, btn_up, btn_down, btn_left, btn_right;
  logic [4:0]          num;
  logic [MAP_BITS-1:0] map;
  logic [1:0]          state;
  logic [4:0]          x_index, y_index;
  logic [9:0]          move_count;
  logic                busy;

  maze_game_ctrl #(.MAX_NUM(19), .MAP_BITS(MAP_BITS), .MOVE_CNT_W(10)) dut (
    .vga_clk(vga_clk), .rst_sys(rst_sys),
    .btn_start(btn_start), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right),
    .num(num), .map(map),
    .state(state), .x_index(x_index), .y_index(y_index),
    .move_count(move_count), .busy(busy)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int x; int y; int cnt; int lat; int blen;
  } mv_t;
  typedef struct {
    int st; int x; int y; int cnt; int lat;
  } st_t;

  mv_t mq[$];
  st_t sq[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int press_cyc = 0;
  int bcnt = 0;
  logic prev_busy = 1'b0;
  logic [1:0] prev_state = 2'b00;

  localparam logic [4:0] B_START = 5'b10000;
  localparam logic [4:0] B_UP    = 5'b01000;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_LEFT  = 5'b00010;
  localparam logic [4:0] B_RIGHT = 5'b00001;

  always @(posedge vga_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_btns(input logic [4:0] m);
    {btn_start, btn_up, btn_down, btn_left, btn_right} = m;
  endtask

  task automatic press(input logic [4:0] m);
    @(posedge vga_clk);
    #1;
    set_btns(m);
    press_cyc = cyc;
    repeat (3) @(posedge vga_clk);
    #1;
    set_btns(5'b0);
    repeat (6) @(posedge vga_clk);
  endtask

  task automatic mv(input logic [4:0] m, input int ex, input int ey, input int ecnt);
    mv_t e;
    e.x = ex; e.y = ey; e.cnt = ecnt; e.lat = 5; e.blen = 2;
    mq.push_back(e);
    press(m);
  endtask

  task automatic exp_state(input int st, input int ex, input int ey, input int ecnt, input int lat);
    st_t e;
    e.st = st; e.x = ex; e.y = ey; e.cnt = ecnt; e.lat = lat;
    sq.push_back(e);
  endtask

  // Monitor: a move is reported when busy drops, a screen change when state moves.
  always @(negedge vga_clk) begin
    mv_t m;
    st_t s;
    if (busy) bcnt++;
    if (prev_busy && !busy) begin
      if (mq.size() == 0) begin
        chk("unexpected_move", 1, 0);
      end else begin
        m = mq.pop_front();
        chk("move_x", int'(x_index), m.x);
        chk("move_y", int'(y_index), m.y);
        chk("move_count", int'(move_count), m.cnt);
        chk("busy_len", bcnt, m.blen);
        if (m.lat != 0) chk("move_latency", cyc - press_cyc, m.lat);
      end
      bcnt = 0;
    end
    if (state != prev_state) begin
      if (sq.size() == 0) begin
        chk("unexpected_state", int'(state), int'(prev_state));
      end else begin
        s = sq.pop_front();
        chk("state", int'(state), s.st);
        chk("state_x", int'(x_index), s.x);
        chk("state_y", int'(y_index), s.y);
        chk("state_count", int'(move_count), s.cnt);
        if (s.lat != 0) chk("state_latency", cyc - press_cyc, s.lat);
      end
    end
    prev_busy  = busy;
    prev_state = state;
  end

  task automatic chk_reset_state();
    chk("rst_state", int'(state), 0);
    chk("rst_x", int'(x_index), 1);
    chk("rst_y", int'(y_index), 1);
    chk("rst_count", int'(move_count), 0);
    chk("rst_busy", int'(busy), 0);
  endtask

  initial begin
    mv_t e;
    rst_sys = 1'b0;
    set_btns(5'b0);
    num = 5'd7;
    map = '0;
    for (int y = 0; y < 7; y++)
      for (int x = 0; x < 7; x++)
        if (x == 0 || y == 0 || x == 6 || y == 6) map[y*7+x] = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1 rst_sys = 1'b1;
    @(negedge vga_clk);
    chk_reset_state();

    // Start a 7x7 game, then wall, moves, simultaneous and dropped pulses.
    exp_state(1, 1, 1, 0, 3);
    press(B_START);
    mv(B_UP, 1, 1, 0);
    mv(B_RIGHT, 2, 1, 1);
    press(B_UP | B_RIGHT);
    press(B_START);

    e.x = 3; e.y = 1; e.cnt = 2; e.lat = 5; e.blen = 2;
    mq.push_back(e);
    @(posedge vga_clk);
    #1 set_btns(B_RIGHT);
    press_cyc = cyc;
    @(posedge vga_clk);
    #1 set_btns(5'b0);
    @(posedge vga_clk);
    #1 set_btns(B_RIGHT);
    repeat (3) @(posedge vga_clk);
    #1 set_btns(5'b0);
    repeat (8) @(posedge vga_clk);

    mv(B_RIGHT, 4, 1, 3);
    mv(B_RIGHT, 5, 1, 4);
    mv(B_RIGHT, 5, 1, 4);
    mv(B_DOWN, 5, 2, 5);
    mv(B_DOWN, 5, 3, 6);
    mv(B_DOWN, 5, 4, 7);
    exp_state(2, 5, 5, 8, 6);
    mv(B_DOWN, 5, 5, 8);
    press(B_LEFT);
    press(B_UP);
    exp_state(0, 1, 1, 0, 3);
    press(B_START);

    // Reset arriving while the move is in its CHECK cycle.
    exp_state(1, 1, 1, 0, 3);
    press(B_START);
    e.x = 1; e.y = 1; e.cnt = 0; e.lat = 0; e.blen = 1;
    mq.push_back(e);
    exp_state(0, 1, 1, 0, 0);
    @(posedge vga_clk);
    #1 set_btns(B_RIGHT);
    repeat (3) @(posedge vga_clk);
    #7 rst_sys = 1'b0;
    set_btns(5'b0);
    repeat (2) @(posedge vga_clk);
    #1 rst_sys = 1'b1;
    @(negedge vga_clk);
    chk_reset_state();
    repeat (4) @(posedge vga_clk);

    // Full-size 19x19 open map; num change after start must not matter.
    map = '0;
    num = 5'd19;
    exp_state(1, 1, 1, 0, 3);
    press(B_START);
    num = 5'd5;
    mv(B_LEFT, 0, 1, 1);
    mv(B_LEFT, 0, 1, 1);
    for (int i = 1; i <= 18; i++) mv(B_RIGHT, i, 1, 1 + i);
    for (int i = 2; i <= 18; i++) mv(B_DOWN, 18, i, 18 + i);
    mv(B_RIGHT, 18, 18, 36);
    mv(B_DOWN, 18, 18, 36);
    mv(B_LEFT, 17, 18, 37);
    map[360] = 1'b1;
    mv(B_RIGHT, 17, 18, 37);
    map[360] = 1'b0;
    mv(B_RIGHT, 18, 18, 38);

    repeat (10) @(posedge vga_clk);
    chk("pending_moves", mq.size(), 0);
    chk("pending_states", sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
